// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage and its register-file interface.
package wb_pkg;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } wb_state_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of upstream, data-memory and register-file signals seen by the writeback stage.
interface wb_stage_if;
  import wb_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_dat;
  logic          ld_req;
  logic [AW-1:0] ld_dst;
  logic [DW-1:0] ld_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_dat;
  logic          stall;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat;
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic [DW-1:0] rfA;
  logic [DW-1:0] rfB;
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;

  modport master (
    output alu_valid, alu_dst, alu_dat, ld_req, ld_dst, ld_addr, mem_dat,
           rd_addrA, rd_addrB, rfA, rfB,
    input  mem_rd_en, mem_addr, stall, rf_wr_en, rf_wr_addr, rf_dat, opA, opB
  );

  modport slave (
    input  alu_valid, alu_dst, alu_dat, ld_req, ld_dst, ld_addr, mem_dat,
           rd_addrA, rd_addrB, rfA, rfB,
    output mem_rd_en, mem_addr, stall, rf_wr_en, rf_wr_addr, rf_dat, opA, opB
  );

endinterface

// File: rtl/wb_bypass.sv
// Two-port forwarding mux: a read that hits the register being written sees the new value.
module wb_bypass
  import wb_pkg::*;
(
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b
);

  assign op_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_dat : rf_a;
  assign op_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_dat : rf_b;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single writeback register for ALU results and multi-cycle loads,
// stalling upstream while a load is outstanding, plus operand bypass.
module wb_stage
  import wb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  wb_state_t     state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] ld_dst_p1;
  wb_reg_t       wb_p1;
  logic          issue;
  logic          last_beat;

  // A load issues only from IDLE; reset blocks the strobe so a load cannot start while clearing.
  assign issue     = (state == IDLE) && bus.ld_req && !reset;
  assign last_beat = (state == LOAD_WAIT) && (cnt == CW'(1));

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = issue ? bus.ld_addr : '0;
  assign bus.stall     = (state == LOAD_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      wb_p1 <= '0;
    end else begin
      wb_p1.en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.alu_valid) begin
            wb_p1 <= '{en: 1'b1, addr: bus.alu_dst, dat: bus.alu_dat};
          end
          if (bus.ld_req) begin
            cnt   <= CW'(MEM_LAT);
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          cnt <= cnt - CW'(1);
          if (last_beat) begin
            wb_p1 <= '{en: 1'b1, addr: ld_dst_p1, dat: bus.mem_dat};
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load destination is pure data; it is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    if (issue) begin
      ld_dst_p1 <= bus.ld_dst;
    end
  end

  assign bus.rf_wr_en   = wb_p1.en;
  assign bus.rf_wr_addr = wb_p1.addr;
  assign bus.rf_dat     = wb_p1.dat;

  wb_bypass u_bypass (
    .wr_en     (wb_p1.en),
    .wr_addr   (wb_p1.addr),
    .wr_dat    (wb_p1.dat),
    .rd_addr_a (bus.rd_addrA),
    .rd_addr_b (bus.rd_addrB),
    .rf_a      (bus.rfA),
    .rf_b      (bus.rfB),
    .op_a      (bus.opA),
    .op_b      (bus.opB)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register-file writes are queued when stimulus is
// driven and matched (cycle, address, data) whenever the stage raises its write enable.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int MEM_LAT = 2;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  wr_t  sb[$];

  wb_stage_if bus ();

  wb_stage #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_dst   = '0;
    bus.alu_dat   = '0;
    bus.ld_req    = 1'b0;
    bus.ld_dst    = '0;
    bus.ld_addr   = '0;
    bus.mem_dat   = '0;
    bus.rd_addrA  = '0;
    bus.rd_addrB  = '0;
    bus.rfA       = '0;
    bus.rfB       = '0;
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.cyc  = c;
    w.addr = a;
    w.dat  = d;
    sb.push_back(w);
  endtask

  // Write monitor: every enabled write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.rf_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("wr_unexpected", 32'(bus.rf_wr_en), 32'd0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check_val("wr_cycle", 32'(cyc), 32'(w.cyc));
        check_val("wr_addr", 32'(bus.rf_wr_addr), 32'(w.addr));
        check_val("wr_dat", 32'(bus.rf_dat), 32'(w.dat));
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    idle_inputs();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      bus.alu_valid = 1'($urandom);
      bus.alu_dst   = AW'($urandom);
      bus.alu_dat   = DW'($urandom);
      bus.ld_req    = 1'($urandom);
      bus.ld_dst    = AW'($urandom);
      bus.ld_addr   = DW'($urandom);
      bus.mem_dat   = DW'($urandom);
      bus.rd_addrA  = AW'($urandom);
      bus.rd_addrB  = AW'($urandom);
      bus.rfA       = DW'($urandom);
      bus.rfB       = DW'($urandom);
      @(negedge clk);
      check_val("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
      check_val("rst_stall", 32'(bus.stall), 32'd0);
      check_val("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check_val("rst_opA", 32'(bus.opA), 32'(bus.rfA));
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_val("post_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);

    // ALU writeback to reg3, with bypass on port B
    next_cycle();
    bus.alu_valid = 1'b1;
    bus.alu_dst   = 3'd3;
    bus.alu_dat   = 8'h5A;
    push_wr(cyc + 1, 3'd3, 8'h5A);
    next_cycle();
    idle_inputs();
    bus.rd_addrB = 3'd3;
    bus.rfB      = 8'h00;
    bus.rd_addrA = 3'd2;
    bus.rfA      = 8'h44;
    @(negedge clk);
    check_val("alu_opB_bypass", 32'(bus.opB), 32'h5A);
    check_val("alu_opA_nohit", 32'(bus.opA), 32'h44);
    next_cycle();
    bus.rd_addrB = 3'd3;
    bus.rfB      = 8'h12;
    @(negedge clk);
    check_val("alu_wr_en_drop", 32'(bus.rf_wr_en), 32'd0);
    check_val("stale_no_bypass", 32'(bus.opB), 32'h12);

    // Register 0 is bypassed like any other
    next_cycle();
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.alu_dst   = 3'd0;
    bus.alu_dat   = 8'hA5;
    push_wr(cyc + 1, 3'd0, 8'hA5);
    next_cycle();
    idle_inputs();
    bus.rd_addrA = 3'd0;
    bus.rfA      = 8'hFF;
    @(negedge clk);
    check_val("reg0_bypass", 32'(bus.opA), 32'hA5);

    // Load to reg5 from 0x10
    next_cycle();
    idle_inputs();
    t = cyc;
    bus.ld_req  = 1'b1;
    bus.ld_dst  = 3'd5;
    bus.ld_addr = 8'h10;
    push_wr(t + MEM_LAT + 1, 3'd5, 8'hC3);
    @(negedge clk);
    check_val("ld_mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check_val("ld_mem_addr", 32'(bus.mem_addr), 32'h10);
    check_val("ld_stall_T", 32'(bus.stall), 32'd0);
    for (int k = 1; k <= MEM_LAT; k++) begin
      next_cycle();
      idle_inputs();
      if (k == MEM_LAT) bus.mem_dat = 8'hC3;
      @(negedge clk);
      check_val("ld_stall", 32'(bus.stall), 32'd1);
      check_val("ld_rd_en_off", 32'(bus.mem_rd_en), 32'd0);
      check_val("ld_addr_zero", 32'(bus.mem_addr), 32'd0);
    end
    next_cycle();
    idle_inputs();
    bus.mem_dat  = 8'h3C;
    bus.rd_addrA = 3'd5;
    bus.rfA      = 8'h00;
    bus.rd_addrB = 3'd4;
    bus.rfB      = 8'h77;
    @(negedge clk);
    check_val("ld_stall_end", 32'(bus.stall), 32'd0);
    check_val("ld_opA_bypass", 32'(bus.opA), 32'hC3);
    check_val("ld_opB_nohit", 32'(bus.opB), 32'h77);

    // Simultaneous ALU + load, then ALU held through the stall
    next_cycle();
    idle_inputs();
    t = cyc;
    bus.alu_valid = 1'b1;
    bus.alu_dst   = 3'd1;
    bus.alu_dat   = 8'h11;
    bus.ld_req    = 1'b1;
    bus.ld_dst    = 3'd2;
    bus.ld_addr   = 8'h20;
    push_wr(t + 1, 3'd1, 8'h11);
    push_wr(t + MEM_LAT + 1, 3'd2, 8'hD2);
    @(negedge clk);
    check_val("sim_mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check_val("sim_mem_addr", 32'(bus.mem_addr), 32'h20);
    for (int k = 1; k <= MEM_LAT; k++) begin
      next_cycle();
      bus.ld_req    = 1'b0;
      bus.alu_valid = 1'b1;
      bus.alu_dst   = 3'd6;
      bus.alu_dat   = 8'h66;
      bus.mem_dat   = (k == MEM_LAT) ? 8'hD2 : 8'h00;
      @(negedge clk);
      check_val("sim_stall", 32'(bus.stall), 32'd1);
    end
    next_cycle();
    bus.mem_dat = 8'h00;
    push_wr(cyc + 1, 3'd6, 8'h66);
    @(negedge clk);
    check_val("sim_stall_end", 32'(bus.stall), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);

    // Reset in the middle of a load
    next_cycle();
    idle_inputs();
    bus.ld_req  = 1'b1;
    bus.ld_dst  = 3'd7;
    bus.ld_addr = 8'h30;
    @(negedge clk);
    check_val("rl_mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check_val("rl_stall_in_rst", 32'(bus.stall), 32'd1);
    check_val("rl_rd_en_in_rst", 32'(bus.mem_rd_en), 32'd0);
    next_cycle();
    reset = 1'b0;
    bus.mem_dat = 8'hEE;
    @(negedge clk);
    check_val("rl_stall_clear", 32'(bus.stall), 32'd0);
    next_cycle();
    bus.mem_dat = 8'h00;
    @(negedge clk);
    check_val("rl_no_write", 32'(bus.rf_wr_en), 32'd0);
    next_cycle();
    @(negedge clk);
    check_val("rl_no_write2", 32'(bus.rf_wr_en), 32'd0);

    repeat (3) next_cycle();
    check_val("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
